// File: rtl/chamber_pressure_ctrl_pkg.sv
// Shared airlock definitions: chamber state encoding and the default
// full-pressurization level.
package chamber_pressure_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    EVAC = 2'd2
  } state_t;

  localparam int LEVEL_MAX_DEFAULT = 15;

endpackage

// File: rtl/chamber_pressure_ctrl_level_counter.sv
// Up/down saturating counter for the chamber pressure level; it holds at
// 0 and LEVEL_MAX rather than wrapping.
module level_counter
  import chamber_pressure_ctrl_pkg::*;
#(
  parameter int LEVEL_MAX = LEVEL_MAX_DEFAULT,
  parameter int LW        = $clog2(LEVEL_MAX + 1)
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          inc,
  input  logic          dec,
  output logic [LW-1:0] count
);

  localparam logic [LW-1:0] COUNT_TOP = LW'(LEVEL_MAX);

  logic [LW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && !dec && count_q != COUNT_TOP) begin
      count_d = count_q + LW'(1);
    end else if (dec && !inc && count_q != '0) begin
      count_d = count_q - LW'(1);
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/chamber_pressure_ctrl.sv
// Airlock chamber pressure controller: IDLE/FILL/EVAC sequencer that steps
// the pressure level one unit per cycle while doors stay sealed.
module chamber_pressure_ctrl
  import chamber_pressure_ctrl_pkg::*;
#(
  parameter int LEVEL_MAX = LEVEL_MAX_DEFAULT,
  parameter int LW        = $clog2(LEVEL_MAX + 1)
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          FandP,
  input  logic          EvacReq,
  input  logic          InnerClosed,
  input  logic          OuterClosed,
  output logic [LW-1:0] Level,
  output logic          Pressurized,
  output logic          Evacuated,
  output logic          Filling,
  output logic          Venting,
  output logic          Fault
);

  localparam logic [LW-1:0] LEVEL_TOP = LW'(LEVEL_MAX);

  state_t state_q, state_d;
  logic   fault_q, fault_d;
  logic   inc, dec;
  logic   sealed;

  assign sealed = InnerClosed && OuterClosed;

  // An open door or an opposing request aborts with Fault; a plain request
  // drop is a quiet pause that keeps the level where it is.
  always_comb begin
    state_d = state_q;
    fault_d = 1'b0;
    inc     = 1'b0;
    dec     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (sealed) begin
          if (FandP && EvacReq) begin
            fault_d = 1'b1;
          end else if (FandP && Level != LEVEL_TOP) begin
            state_d = FILL;
          end else if (EvacReq && Level != '0) begin
            state_d = EVAC;
          end
        end
      end
      FILL: begin
        if (!sealed || EvacReq) begin
          state_d = IDLE;
          fault_d = 1'b1;
        end else if (!FandP || Level == LEVEL_TOP) begin
          state_d = IDLE;
        end else begin
          inc = 1'b1;
          if (Level == LEVEL_TOP - LW'(1)) begin
            state_d = IDLE;
          end
        end
      end
      EVAC: begin
        if (!sealed || FandP) begin
          state_d = IDLE;
          fault_d = 1'b1;
        end else if (!EvacReq || Level == '0) begin
          state_d = IDLE;
        end else begin
          dec = 1'b1;
          if (Level == LW'(1)) begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fault_q <= fault_d;
    end
  end

  level_counter #(
    .LEVEL_MAX (LEVEL_MAX),
    .LW        (LW)
  ) u_level_counter (
    .Clock (Clock),
    .Reset (Reset),
    .inc   (inc),
    .dec   (dec),
    .count (Level)
  );

  assign Pressurized = (Level == LEVEL_TOP);
  assign Evacuated   = (Level == '0);
  assign Filling     = (state_q == FILL);
  assign Venting     = (state_q == EVAC);
  assign Fault       = fault_q;

endmodule

// File: tb/tb_chamber_pressure_ctrl.sv
// Directed bench for chamber_pressure_ctrl: fill, evacuate, door abort,
// request conflict, pause/resume and asynchronous reset.
module tb_chamber_pressure_ctrl;

  localparam int LW = 4;

  logic          Clock;
  logic          Reset;
  logic          FandP;
  logic          EvacReq;
  logic          InnerClosed;
  logic          OuterClosed;
  logic [LW-1:0] Level;
  logic          Pressurized;
  logic          Evacuated;
  logic          Filling;
  logic          Venting;
  logic          Fault;

  int total = 0;
  int bad   = 0;
  int ventCycles;

  chamber_pressure_ctrl #(
    .LEVEL_MAX (15)
  ) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .FandP       (FandP),
    .EvacReq     (EvacReq),
    .InnerClosed (InnerClosed),
    .OuterClosed (OuterClosed),
    .Level       (Level),
    .Pressurized (Pressurized),
    .Evacuated   (Evacuated),
    .Filling     (Filling),
    .Venting     (Venting),
    .Fault       (Fault)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic applyStimulus(input logic fandp, input logic evac,
                               input logic inner, input logic outer);
    FandP       = fandp;
    EvacReq     = evac;
    InnerClosed = inner;
    OuterClosed = outer;
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic checkAll(input string tag, input int lvl, input int press,
                          input int evac, input int fill, input int vent,
                          input int flt);
    checkOutput({tag, " level"},       32'(Level),       32'(lvl));
    checkOutput({tag, " pressurized"}, 32'(Pressurized), 32'(press));
    checkOutput({tag, " evacuated"},   32'(Evacuated),   32'(evac));
    checkOutput({tag, " filling"},     32'(Filling),     32'(fill));
    checkOutput({tag, " venting"},     32'(Venting),     32'(vent));
    checkOutput({tag, " fault"},       32'(Fault),       32'(flt));
  endtask

  initial begin
    Reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    #2;
    checkAll("reset", 0, 0, 1, 0, 0, 0);
    step();
    Reset = 1'b0;

    // Fill from empty: one edge to enter FILL, then fifteen increments.
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
    step();
    checkAll("fill_enter", 0, 0, 1, 1, 0, 0);
    for (int k = 2; k <= 15; k++) begin
      step();
      checkOutput($sformatf("fill_edge%0d level", k), 32'(Level), 32'(k - 1));
      checkOutput($sformatf("fill_edge%0d filling", k), 32'(Filling), 32'd1);
    end
    step();
    checkAll("fill_full", 15, 1, 0, 0, 0, 0);
    step();
    checkAll("fill_sat", 15, 1, 0, 0, 0, 0);

    // Evacuate from full while counting venting cycles.
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
    ventCycles = 0;
    step();
    checkAll("evac_enter", 15, 1, 0, 0, 1, 0);
    if (Venting) ventCycles++;
    for (int k = 2; k <= 15; k++) begin
      step();
      if (Venting) ventCycles++;
      checkOutput($sformatf("evac_edge%0d level", k), 32'(Level), 32'(16 - k));
    end
    step();
    if (Venting) ventCycles++;
    checkAll("evac_empty", 0, 0, 1, 0, 0, 0);
    checkOutput("evac_vent_cycles", 32'(ventCycles), 32'd15);

    // Door abort during FILL at level 5.
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
    step();
    for (int k = 1; k <= 5; k++) step();
    checkAll("abort_pre", 5, 0, 0, 1, 0, 0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    step();
    checkAll("abort_edge", 5, 0, 0, 0, 0, 1);
    step();
    checkAll("abort_after", 5, 0, 0, 0, 0, 0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    step();

    // Conflicting requests in IDLE.
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
    step();
    checkAll("conflict", 5, 0, 0, 0, 0, 1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    step();
    checkAll("conflict_after", 5, 0, 0, 0, 0, 0);

    // Pause at 7, then resume with one idle edge before counting.
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
    step();
    step();
    step();
    checkAll("pause_pre", 7, 0, 0, 1, 0, 0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    step();
    checkAll("pause", 7, 0, 0, 0, 0, 0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
    step();
    checkAll("resume_enter", 7, 0, 0, 1, 0, 0);
    step();
    checkAll("resume_8", 8, 0, 0, 1, 0, 0);
    step();
    checkAll("resume_9", 9, 0, 0, 1, 0, 0);

    // Opposing request during FILL aborts with Fault, then EVAC starts.
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
    step();
    checkAll("fill_opp_abort", 9, 0, 0, 0, 0, 1);
    step();
    checkAll("evac_at9", 9, 0, 0, 0, 1, 0);

    // Asynchronous reset between edges while in EVAC.
    #2;
    Reset = 1'b1;
    #1;
    checkAll("async_reset", 0, 0, 1, 0, 0, 0);
    #2;
    Reset = 1'b0;
    step();
    checkAll("post_reset_evac", 0, 0, 1, 0, 0, 0);

    // Requests with a door open are ignored quietly.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    step();
    checkAll("door_open_ignore", 0, 0, 1, 0, 0, 0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
    step();
    checkAll("fresh_fill", 0, 0, 1, 1, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/chamber_pressure_ctrl.md
CHAMBER_PRESSURE_CTRL -- requirements
Module: chamber_pressure_ctrl

Interface
REQ-001 Parameter: LEVEL_MAX, 15, chamber pressure level at full pressurization; legal range 2..255.
REQ-002 Parameter: LW, $clog2(LEVEL_MAX+1), width of the level count.
REQ-003 Port: Clock  input  1  sole clock; all state changes on its rising edge.
REQ-004 Port: Reset  input  1  asynchronous, active-high reset.
REQ-005 Port: FandP  input  1  fill-and-pressurize request from the upstream fill stage.
REQ-006 Port: EvacReq  input  1  pump-down request.
REQ-007 Port: InnerClosed  input  1  inner door closed.
REQ-008 Port: OuterClosed  input  1  outer door closed.
REQ-009 Port: Level  output  LW  current chamber pressure level, registered.
REQ-010 Port: Pressurized  output  1  high when Level == LEVEL_MAX.
REQ-011 Port: Evacuated  output  1  high when Level == 0.
REQ-012 Port: Filling  output  1  high while state == FILL.
REQ-013 Port: Venting  output  1  high while state == EVAC.
REQ-014 Port: Fault  output  1  registered single-cycle pulse on an illegal request or door-open abort.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, FILL and EVAC.
REQ-016 Doors-sealed condition SHALL be InnerClosed && OuterClosed.
REQ-017 In IDLE with FandP=1, EvacReq=0, doors sealed and Level<LEVEL_MAX, the next state SHALL be FILL; Level is unchanged on that edge.
REQ-018 In IDLE with EvacReq=1, FandP=0, doors sealed and Level>0, the next state SHALL be EVAC; Level is unchanged on that edge.
REQ-019 In IDLE with FandP=1 and EvacReq=1 in the same cycle, the state SHALL remain IDLE and Fault SHALL pulse high on the next edge.
REQ-020 In IDLE, a request made while the doors are not sealed SHALL be ignored without Fault.
REQ-021 In FILL with FandP=1 and doors sealed, Level SHALL increment by 1 per edge; on the edge where Level becomes LEVEL_MAX, the state SHALL return to IDLE.
REQ-022 In EVAC with EvacReq=1 and doors sealed, Level SHALL decrement by 1 per edge; on the edge where Level becomes 0, the state SHALL return to IDLE.
REQ-023 In FILL, FandP=0 (or in EVAC, EvacReq=0) SHALL return the state to IDLE with Level held and no Fault (pause).
REQ-024 In FILL or EVAC, either door opening SHALL return the state to IDLE with Level held, and Fault SHALL pulse high for one cycle; door-open takes priority over request drop.
REQ-025 In FILL, an EvacReq assertion (or in EVAC, an FandP assertion) SHALL be treated as in REQ-024: return to IDLE and pulse Fault.
REQ-026 Level SHALL saturate, never wrapping below 0 or above LEVEL_MAX.
REQ-027 Pressurized and Evacuated SHALL be decoded from the registered Level with zero added latency.

Reset
REQ-028 On Reset the block SHALL force state IDLE, Level=0 and Fault=0 immediately, independent of Clock.
REQ-029 The reset output values SHALL therefore be Evacuated=1, Pressurized=0, Filling=0 and Venting=0.
REQ-030 Reset asserted mid-FILL or mid-EVAC SHALL discard progress; after release, the block SHALL require a fresh request.

Structure
REQ-031 The state encoding typedef (IDLE/FILL/EVAC) and the default LEVEL_MAX SHALL reside in a shared airlock package.
REQ-032 Up/down saturating level counting SHALL be a sub-module named level_counter, with ports Clock, Reset, inc, dec and count.

Verification
REQ-033 Fill from 0: reset, doors sealed, FandP=1 held -> Filling=1 after edge 1; Level=15 and Pressurized=1 after edge 16; Filling=0 thereafter.
REQ-034 Evacuate from 15: EvacReq=1, doors sealed -> Level=0 and Evacuated=1 after edge 16; Venting lasts 15 cycles.
REQ-035 Door abort: during FILL at Level=5, OuterClosed=0 -> next edge gives IDLE, Level=5, Fault=1 for exactly one cycle.
REQ-036 Conflict: in IDLE, FandP=1 and EvacReq=1 together -> state stays IDLE, Level unchanged, Fault pulse.
REQ-037 Pause/resume: drop FandP at Level=7 -> IDLE with Level=7; reassert FandP -> one idle edge, then counting resumes 8, 9, ...
REQ-038 Async reset mid-EVAC at Level=9: assert Reset between edges -> Level=0 and Evacuated=1 immediately, with no clock edge required.
